// File: rtl/prbs7_checker_pkg.sv
// prbs7_checker_pkg: shared state encodings and PRBS7 constants
// x^7+x^6+1 taps and the seed length used by the checker and its LFSR
package prbs7_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam int LFSR_W   = 7;
    localparam int TAP_HI   = 6;
    localparam int TAP_LO   = 5;
    localparam int SEED_LEN = 7;

endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: 7-bit PRBS7 register with load and advance controls
// Loads the incoming bit while seeding, otherwise tracks its own prediction
module prbs7_lfsr
    import prbs7_checker_pkg::*;
(
    input  logic Clock,
    input  logic Resetn,
    input  logic i_load,
    input  logic i_adv,
    input  logic i_bit,
    output logic o_exp,
    output logic o_seed_zero
);

    logic [LFSR_W-1:0] r_q;

    // shift in D while seeding, or the predicted bit while tracking
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= {r_q[LFSR_W-2:0], i_bit};
        end else if (i_adv) begin
            r_q <= {r_q[LFSR_W-2:0], o_exp};
        end
    end

    assign o_exp       = r_q[TAP_HI] ^ r_q[TAP_LO];
    assign o_seed_zero = ({r_q[LFSR_W-2:0], i_bit} == '0);

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker: PRBS7 seed/verify/lock checker with error window
// Counts errors only while locked; too many errors in a window drops lock
module prbs7_checker
    import prbs7_checker_pkg::*;
#(
    parameter int VERIFY_LEN  = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Valid,
    input  logic             D,
    input  logic             Clear,
    output logic             Locked,
    output logic             ErrPulse,
    output logic [CNT_W-1:0] ErrCount,
    output logic [1:0]       State
);

    localparam int SW = $clog2(SEED_LEN);
    localparam int MW = $clog2(VERIFY_LEN + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    localparam logic [SW-1:0] SEED_LAST  = SW'(SEED_LEN - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(VERIFY_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] LOSS_CNT   = EW'(LOSS_THRESH);

    state_t           r_state;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_cnt;
    logic [SW-1:0]    r_scnt;
    logic [MW-1:0]    r_mcnt;
    logic [WW-1:0]    r_wcnt;
    logic [EW-1:0]    r_werr;

    logic          w_load;
    logic          w_adv;
    logic          w_exp;
    logic          w_seed_zero;
    logic          w_err;
    logic          w_wrap;
    logic [EW-1:0] w_werr_nxt;

    assign w_load = Valid && (r_state == ST_SEED);
    assign w_adv  = Valid && (r_state != ST_SEED);
    assign w_err  = D ^ w_exp;
    assign w_wrap = (r_wcnt == WIN_LAST);

    assign w_werr_nxt = w_wrap ? EW'(w_err)
                               : r_werr + EW'(w_err);

    prbs7_lfsr u_lfsr (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .i_load      (w_load),
        .i_adv       (w_adv),
        .i_bit       (D),
        .o_exp       (w_exp),
        .o_seed_zero (w_seed_zero)
    );

    // seed/verify/lock sequencing with registered status outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state     <= ST_SEED;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_scnt      <= '0;
            r_mcnt      <= '0;
            r_wcnt      <= '0;
            r_werr      <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (Clear) begin
                r_err_cnt <= '0;
            end
            if (Valid) begin
                unique case (r_state)
                    ST_SEED: begin
                        if (r_scnt == SEED_LAST) begin
                            r_scnt <= '0;
                            r_mcnt <= '0;
                            if (!w_seed_zero) begin
                                r_state <= ST_VERIFY;
                            end
                        end else begin
                            r_scnt <= r_scnt + SW'(1);
                        end
                    end
                    ST_VERIFY: begin
                        if (w_err) begin
                            r_state <= ST_SEED;
                            r_scnt  <= '0;
                            r_mcnt  <= '0;
                        end else if (r_mcnt == MATCH_LAST) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_mcnt   <= '0;
                            r_wcnt   <= '0;
                            r_werr   <= '0;
                        end else begin
                            r_mcnt <= r_mcnt + MW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        r_err_pulse <= w_err;
                        if (w_err && !Clear && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                        end
                        if (w_werr_nxt == LOSS_CNT) begin
                            r_state  <= ST_SEED;
                            r_locked <= 1'b0;
                            r_scnt   <= '0;
                            r_wcnt   <= '0;
                            r_werr   <= '0;
                        end else begin
                            r_wcnt <= w_wrap ? '0 : r_wcnt + WW'(1);
                            r_werr <= w_werr_nxt;
                        end
                    end
                    default: begin
                        r_state <= ST_SEED;
                    end
                endcase
            end
        end
    end

    assign Locked   = r_locked;
    assign ErrPulse = r_err_pulse;
    assign ErrCount = r_err_cnt;
    assign State    = r_state;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: directed scenarios for the PRBS7 checker
// Reference stream comes from an independent x^7+x^6+1 generator
module tb_prbs7_checker;

    logic        Clock;
    logic        Resetn;
    logic        Valid;
    logic        D;
    logic        Clear;
    logic        Locked;
    logic        ErrPulse;
    logic [15:0] ErrCount;
    logic [1:0]  State;

    int errors;
    int checks;
    logic [6:0] g;

    prbs7_checker dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Valid    (Valid),
        .D        (D),
        .Clear    (Clear),
        .Locked   (Locked),
        .ErrPulse (ErrPulse),
        .ErrCount (ErrCount),
        .State    (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input logic v, input logic d, input logic c);
        Valid = v;
        D     = d;
        Clear = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic gen(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (State !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b want 00", State);
        end
        checks++;
        if (Locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked: got %b want 0", Locked);
        end
        checks++;
        if (ErrCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_errcount: got %0d want 0", ErrCount);
        end
        checks++;
        if (ErrPulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_errpulse: got %b want 0", ErrPulse);
        end
        Resetn = 1'b1;
    endtask

    task automatic test_lock;
        logic b;
        int pulses;
        pulses = 0;
        g = 7'h01;
        for (int i = 0; i < 1000; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            if (ErrPulse === 1'b1) pulses++;
            if (i == 6) begin
                checks++;
                if (State !== 2'b01) begin
                    errors++;
                    $display("FAIL seed_to_verify: got %b want 01", State);
                end
            end
            if (i == 21) begin
                checks++;
                if (Locked !== 1'b0) begin
                    errors++;
                    $display("FAIL early_lock: Locked=%b want 0", Locked);
                end
            end
            if (i == 22) begin
                checks++;
                if (Locked !== 1'b1 || State !== 2'b10) begin
                    errors++;
                    $display("FAIL lock_at_23: Locked=%b State=%b want 1/10",
                             Locked, State);
                end
            end
        end
        checks++;
        if (ErrCount !== 16'd0 || pulses != 0) begin
            errors++;
            $display("FAIL clean_1000: ErrCount=%0d pulses=%0d want 0/0",
                     ErrCount, pulses);
        end
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL clean_locked: Locked=%b want 1", Locked);
        end
    endtask

    task automatic test_single_error;
        logic b;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            gen(b);
            step(1'b1, (i == 100) ? ~b : b, 1'b0);
            if (ErrPulse === 1'b1) pulses++;
            if (i == 100) begin
                checks++;
                if (ErrPulse !== 1'b1) begin
                    errors++;
                    $display("FAIL err_latency: ErrPulse=%b want 1", ErrPulse);
                end
            end
        end
        checks++;
        if (pulses != 1 || ErrCount !== 16'd1) begin
            errors++;
            $display("FAIL single_err: pulses=%0d ErrCount=%0d want 1/1",
                     pulses, ErrCount);
        end
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err_lock: Locked=%b want 1", Locked);
        end
    endtask

    task automatic test_loss_relock;
        logic b;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (ErrCount !== 16'd0) begin
            errors++;
            $display("FAIL clear_idle: ErrCount=%0d want 0", ErrCount);
        end
        for (int i = 0; i < 7; i++) begin
            gen(b);
            step(1'b1, (i % 2 == 0) ? ~b : b, 1'b0);
            if (i == 4) begin
                checks++;
                if (Locked !== 1'b1 || ErrPulse !== 1'b1) begin
                    errors++;
                    $display("FAIL third_err: Locked=%b ErrPulse=%b want 1/1",
                             Locked, ErrPulse);
                end
            end
            if (i == 6) begin
                checks++;
                if (Locked !== 1'b0 || State !== 2'b00 || ErrPulse !== 1'b1) begin
                    errors++;
                    $display("FAIL loss: Locked=%b State=%b ErrPulse=%b want 0/00/1",
                             Locked, State, ErrPulse);
                end
            end
        end
        for (int i = 0; i < 23; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            if (i == 21) begin
                checks++;
                if (Locked !== 1'b0) begin
                    errors++;
                    $display("FAIL relock_early: Locked=%b want 0", Locked);
                end
            end
        end
        checks++;
        if (Locked !== 1'b1 || ErrCount !== 16'd4) begin
            errors++;
            $display("FAIL relock: Locked=%b ErrCount=%0d want 1/4",
                     Locked, ErrCount);
        end
    endtask

    task automatic test_midreset;
        Resetn = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (State !== 2'b00 || Locked !== 1'b0 ||
            ErrCount !== 16'd0 || ErrPulse !== 1'b0) begin
            errors++;
            $display("FAIL midreset: State=%b Locked=%b ErrCount=%0d ErrPulse=%b",
                     State, Locked, ErrCount, ErrPulse);
        end
        Resetn = 1'b1;
    endtask

    task automatic test_zeros;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (State !== 2'b00 || Locked !== 1'b0) begin
                errors++;
                $display("FAIL zeros_cyc%0d: State=%b Locked=%b want 00/0",
                         i, State, Locked);
            end
        end
    endtask

    task automatic test_clear_valid;
        logic b;
        Resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        Resetn = 1'b1;
        g = 7'h01;
        for (int i = 0; i < 23; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            if (i == 21) begin
                checks++;
                if (Locked !== 1'b0) begin
                    errors++;
                    $display("FAIL half_rate_early: Locked=%b want 0", Locked);
                end
            end
            if (i == 22) begin
                checks++;
                if (Locked !== 1'b1) begin
                    errors++;
                    $display("FAIL half_rate_lock: Locked=%b want 1", Locked);
                end
            end
            step(1'b0, ~b, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            step(1'b0, ~b, 1'b0);
        end
        gen(b);
        step(1'b1, ~b, 1'b0);
        checks++;
        if (ErrPulse !== 1'b1 || ErrCount !== 16'd1) begin
            errors++;
            $display("FAIL hr_err: ErrPulse=%b ErrCount=%0d want 1/1",
                     ErrPulse, ErrCount);
        end
        step(1'b0, b, 1'b0);
        checks++;
        if (ErrPulse !== 1'b0 || ErrCount !== 16'd1) begin
            errors++;
            $display("FAIL hr_hold: ErrPulse=%b ErrCount=%0d want 0/1",
                     ErrPulse, ErrCount);
        end
        for (int i = 0; i < 5; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            step(1'b0, ~b, 1'b0);
        end
        gen(b);
        step(1'b1, ~b, 1'b1);
        checks++;
        if (ErrPulse !== 1'b1 || ErrCount !== 16'd0 || Locked !== 1'b1) begin
            errors++;
            $display("FAIL clear_prio: ErrPulse=%b ErrCount=%0d Locked=%b want 1/0/1",
                     ErrPulse, ErrCount, Locked);
        end
        step(1'b0, b, 1'b0);
        checks++;
        if (ErrPulse !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse_len: ErrPulse=%b want 0", ErrPulse);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        g      = 7'h01;
        Resetn = 1'b0;
        Valid  = 1'b0;
        D      = 1'b0;
        Clear  = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_midreset();
        test_zeros();
        test_clear_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 Parameter VERIFY_LEN, default 16, is the number of consecutive correct bits required before lock is declared.
REQ-002 Parameter WINDOW, default 64, is the length in valid bits of the loss-of-lock error window.
REQ-003 Parameter LOSS_THRESH, default 4, is the number of errors within one window that forces loss of lock.
REQ-004 Parameter CNT_W, default 16, is the width of the error counter.
REQ-005 Port Clock, input, 1 bit, is the single rising-edge clock.
REQ-006 Port Resetn, input, 1 bit, is the synchronous active-low reset.
REQ-007 Port Valid, input, 1 bit, qualifies D; the checker samples D only on clock edges where Valid=1.
REQ-008 Port D, input, 1 bit, is the serial bit under test, e.g. the Q of an upstream flop.
REQ-009 Port Clear, input, 1 bit, is a synchronous clear of ErrCount.
REQ-010 Port Locked, output, 1 bit, is high while the state is LOCKED.
REQ-011 Port ErrPulse, output, 1 bit, is a one-cycle pulse for each mismatched bit while LOCKED.
REQ-012 Port ErrCount, output, CNT_W bits, is the saturating count of errors detected while LOCKED.
REQ-013 Port State, output, 2 bits, encodes the state: SEED=00, VERIFY=01, LOCKED=10.

Function
REQ-014 The pattern SHALL be PRBS7 (x^7+x^6+1): expected bit = lfsr[6]^lfsr[5]; lfsr shifts left each valid cycle, with the new bit entering lfsr[0].
REQ-015 SEED SHALL shift 7 valid D bits into lfsr, then go to VERIFY, except that an all-zero lfsr SHALL restart SEED.
REQ-016 VERIFY SHALL compare D against the expected bit and shift the expected bit into lfsr; a match SHALL increment the match count.
REQ-017 In VERIFY, a mismatch SHALL return the block to SEED with the seed count and match count at 0; it SHALL NOT assert ErrPulse or change ErrCount.
REQ-018 On the VERIFY_LEN-th consecutive match, the state SHALL become LOCKED, with Locked=1 registered on that edge.
REQ-019 LOCKED SHALL free-run lfsr on the expected bit; each mismatch SHALL assert ErrPulse on the next cycle, increment ErrCount (saturating at all-ones), and increment the window error count.
REQ-020 A window bit counter SHALL count valid bits 0..WINDOW-1 and wrap; on wrap the window error count SHALL reset to 0, or to 1 if the wrap bit itself is an error.
REQ-021 When the window error count reaches LOSS_THRESH, the state SHALL become SEED and Locked SHALL fall on the same edge; ErrCount SHALL be retained.
REQ-022 Valid=0 SHALL hold all state, counters and lfsr, and ErrPulse SHALL be 0.
REQ-023 Clear=1 SHALL set ErrCount to 0 and SHALL take priority over a simultaneous error increment; ErrPulse still fires.
REQ-024 The latency from a sampled bit to ErrPulse SHALL be exactly 1 clock.

Reset
REQ-025 Resetn=0 at a rising Clock edge SHALL set State=SEED, Locked=0, ErrPulse=0, ErrCount=0, lfsr=0, and all internal counters to 0.
REQ-026 Reset mid-operation, in any state, SHALL take priority over Valid and Clear; no output SHALL change asynchronously.

Structure
REQ-027 A shared package SHALL hold the state encodings, the PRBS7 tap positions and the seed length 7.
REQ-028 A sub-module prbs7_lfsr SHALL provide the 7-bit register with load-bit/advance controls and an expected-bit output.

Verification
REQ-029 Scenario: Resetn=0 for 2 clocks -> State=00, Locked=0, ErrCount=0, ErrPulse=0.
REQ-030 Scenario: clean PRBS7 from seed 7'h01 with Valid=1 -> Locked=1 after the 23rd valid bit (7+16); ErrCount=0 after 1000 bits.
REQ-031 Scenario: after lock, flip bit 100 -> exactly one ErrPulse, ErrCount=1, Locked stays 1.
REQ-032 Scenario: after lock, 4 flips inside one 64-bit window -> Locked falls on the 4th error; relock after 23 clean bits; ErrCount=4.
REQ-033 Scenario: D=0 constantly -> State stays SEED and Locked=0 for 200 cycles.
REQ-034 Scenario: Clear coincident with an error, plus Valid toggling 1/0 every cycle -> ErrCount=0, ErrPulse=1, lock timing doubled in clocks but identical in valid bits.
